// File: rtl/omsp_spm_key_writer.sv
// rtl/omsp_spm_key_writer.sv - SPM key writer: selects an SM and streams its key as 16-bit words
//
// Takes a full module key and a target SM ID from the key source. It selects the SM on
// spm_key_select and writes the key one 16-bit word per cycle into the SPM array via
// key_in/key_idx/write_key. It reports done or error to the requester.
//
// Optional feature macro: SPM_KEY_READBACK_EN. When it is defined, the writer compares
// key_rb with the latched key for one cycle after the last word is written.
//
// Ports:
//   mclk, puc_rst          clock, synchronous active-high reset
//   start, abort           request pulse (sampled in IDLE), cancel in-flight request
//   target_id, key         SM ID and key to store (key bit 0 = MSB of word 0)
//   spm_key_select_valid   selected SM exists and is enabled (combinational from SPM control)
//   key_rb                 key readback from SPM control (readback build only)
//   spm_key_select         selected SM ID
//   key_in, key_idx        word being written and its index
//   write_key              write strobe
//   busy, done, error      status: not idle, one-cycle success pulse, one-cycle failure pulse
module omsp_spm_key_writer #(
  parameter int KEY_BITS     = 64,
  parameter int KEY_IDX_SIZE = 2
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [15:0]             target_id,
  input  logic [0:KEY_BITS-1]     key,
  input  logic                    spm_key_select_valid,
  input  logic [0:KEY_BITS-1]     key_rb,
  output logic [15:0]             spm_key_select,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    write_key,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int                    KEY_WORDS = KEY_BITS / 16;
  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX  = KEY_IDX_SIZE'(KEY_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
`ifdef SPM_KEY_READBACK_EN
  localparam logic [2:0] S_VERIFY = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [KEY_IDX_SIZE-1:0] cnt_q, cnt_d;
  logic [15:0]             id_q, id_d;
  logic [0:KEY_BITS-1]     key_q, key_d;

`ifndef SPM_KEY_READBACK_EN
  logic unused_key_rb;
  assign unused_key_rb = ^key_rb;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        // start beats abort here: abort has no meaning while idle
        if (start) begin
          key_d   = key;
          id_d    = target_id;
          cnt_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (abort)                     state_d = S_IDLE;
        else if (spm_key_select_valid) state_d = S_WRITE;
        else                           state_d = S_FAIL;
      end
      S_WRITE: begin
        // The SM can vanish mid-transfer; the word in that cycle is not strobed.
        if (abort)                      state_d = S_IDLE;
        else if (!spm_key_select_valid) state_d = S_FAIL;
        else if (cnt_q == LAST_IDX) begin
`ifdef SPM_KEY_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SPM_KEY_READBACK_EN
      S_VERIFY: begin
        if (abort)                                           state_d = S_IDLE;
        else if (spm_key_select_valid && (key_rb == key_q)) state_d = S_DONE;
        else                                                 state_d = S_FAIL;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      key_q   <= key_d;
    end
  end

  logic sel_active;
  logic in_write;

  always_comb begin
    in_write   = (state_q == S_WRITE);
    sel_active = (state_q == S_SELECT) || in_write;
`ifdef SPM_KEY_READBACK_EN
    sel_active = sel_active || (state_q == S_VERIFY);
`endif
    spm_key_select = sel_active ? id_q : 16'h0000;
    key_in         = in_write ? key_q[16*int'(cnt_q) +: 16] : 16'h0000;
    key_idx        = in_write ? cnt_q : '0;
    write_key      = in_write && spm_key_select_valid && !abort;
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
    error          = (state_q == S_FAIL);
  end

endmodule

// File: doc/omsp_spm_key_writer.md
Name: omsp_spm_key_writer

Overview:
- Writer side of the SPM key-storage interface. It takes a full module key plus a target SM ID, selects the SM via spm_key_select, and streams the key as 16-bit words on key_in/key_idx/write_key into the SPM array behind the SPM control block.
- Sits between the key source (crypto/derivation unit) and omsp_spm_control, and reports completion or failure to the requester.

Parameters:
KEY_BITS, 64, key width in bits; must be a multiple of 16 and equal to `SECURITY.
KEY_IDX_SIZE, 2, key_idx width; must satisfy 2**KEY_IDX_SIZE >= KEY_BITS/16.

Ports:
mclk  input  1  core clock; single clock domain.
puc_rst  input  1  reset, synchronous, active-high.
start  input  1  request pulse; sampled only in IDLE.
abort  input  1  cancel the in-flight request.
target_id  input  16  ID of the SM to receive the key.
key  input  [0:KEY_BITS-1]  key to store; bit 0 is the MSB of word 0.
spm_key_select_valid  input  1  from SPM control; high when spm_key_select matches an enabled SM (combinational).
key_rb  input  [0:KEY_BITS-1]  key_out readback from SPM control (used only with the optional feature).
spm_key_select  output  16  selected SM ID.
key_in  output  16  key word being written.
key_idx  output  KEY_IDX_SIZE  index of the word on key_in.
write_key  output  1  write strobe.
busy  output  1  high in any state except IDLE.
done  output  1  one-cycle success pulse.
error  output  1  one-cycle failure pulse.

Behaviour:
- Reset (synchronous, puc_rst high at an edge): state=IDLE, word counter=0, latched key/ID=0.
  - All outputs 0: spm_key_select, key_in, key_idx, write_key, busy, done, error.
  - Reset mid-transfer stops writes from the next cycle. No done or error pulse is produced.
- States: IDLE, SELECT, WRITE, VERIFY (optional), DONE, FAIL.
- IDLE:
  - start=1 → latch key and target_id, clear counter, go to SELECT.
  - start while busy is ignored; no queuing.
- SELECT (1 cycle):
  - spm_key_select = latched ID.
  - spm_key_select_valid=1 → WRITE; otherwise → FAIL.
- WRITE (KEY_WORDS = KEY_BITS/16 cycles):
  - spm_key_select = ID.
  - key_idx = counter.
  - key_in = latched key[16*counter +: 16].
  - write_key = spm_key_select_valid (combinational).
  - Counter increments each cycle while valid.
  - valid=0 in any WRITE cycle (SM destroyed concurrently) → no strobe that cycle, go to FAIL.
  - After the word with counter = KEY_WORDS-1 → VERIFY if enabled, else DONE.
  - The counter never wraps: it stops at KEY_WORDS-1.
- DONE (1 cycle): done=1, then IDLE.
- FAIL (1 cycle): error=1, then IDLE.
- Outside SELECT/WRITE/VERIFY: spm_key_select=0, key_in=0, key_idx=0.
- abort=1 in SELECT/WRITE/VERIFY:
  - Go to IDLE next edge; write_key is forced 0 in the abort cycle.
  - No done/error pulse. Words already written stay written.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- busy = (state != IDLE).
- Latency: start at edge N → SELECT in cycle N+1, WRITE in N+2..N+1+KEY_WORDS, done in cycle N+2+KEY_WORDS (+1 with VERIFY).
- done and error are mutually exclusive and never both high.

Optional Feature:
- Macro: SPM_KEY_READBACK_EN.
- Defined: after WRITE, enter VERIFY for 1 cycle with spm_key_select held at the ID.
  - key_rb == latched key and spm_key_select_valid=1 → DONE; otherwise → FAIL.
- Undefined:
  - VERIFY state and key_rb compare logic are absent; the key_rb port stays present but unused.
  - WRITE goes directly to DONE.

Test Plan:
- Reset, then a start while puc_rst=1 → all outputs 0 for the whole reset period; no write_key pulse.
- KEY_BITS=64, target_id=16'h0003, key=64'h0123_4567_89AB_CDEF, valid held 1:
  - write_key high 4 consecutive cycles, key_idx 0,1,2,3 with key_in 16'h0123,16'h4567,16'h89AB,16'hCDEF.
  - done pulse in cycle N+6 (N+7 with readback); error stays 0.
- target_id=16'h0009 with valid=0 in SELECT → no write_key; error pulse in cycle N+2; busy low in cycle N+3.
- Valid drops during the 3rd WRITE cycle → exactly 2 strobes (idx 0,1); error pulse on the next cycle.
- abort asserted during key_idx=1 → 1 strobe total (idx 0); no done/error; busy=0 next cycle.
  - A start pulsed during the transfer is ignored.
- With SPM_KEY_READBACK_EN:
  - key_rb equal to key → done.
  - key_rb with bit 0 flipped → error, no done.
